// File: rtl/cdb_scheduler.sv
// CDB slot arbiter: shares N common-data-bus slots among NUM_FU completing units using
// rotating priority, with starved requesters escalated ahead of the rotation. Completions
// killed by a same-cycle branch squash are dropped before they consume a slot.
module cdb_scheduler #(
  parameter int unsigned N            = 2,
  parameter int unsigned NUM_FU       = 4,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = $clog2(STARVE_LIMIT + 1),
  parameter int unsigned BR_MASK      = 4,
  parameter int unsigned BR_TASK      = 2,
  parameter logic [BR_TASK-1:0] SQUASH_TASK = BR_TASK'(1),
  localparam int unsigned PtrW        = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_FU-1:0]                fu_req_i,
  input  logic [NUM_FU-1:0][BR_MASK-1:0]   fu_b_mask_i,
  input  logic [NUM_FU-1:0][BR_MASK-1:0]   fu_b_id_i,
  input  logic [BR_TASK-1:0]               rem_br_task_i,
  input  logic [BR_MASK-1:0]               rem_b_id_i,
  output logic [NUM_FU-1:0]                gnt_o,
  output logic [N-1:0][NUM_FU-1:0]         gnt_bus_o,
  output logic [NUM_FU-1:0]                stall_sig_o,
  output logic [PtrW-1:0]                  rr_ptr_o,
  output logic [NUM_FU-1:0]                starved_o
);

  localparam logic [CNT_W-1:0] Limit = CNT_W'(STARVE_LIMIT);

  logic [PtrW-1:0]            rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]           wait_q [NUM_FU];
  logic [CNT_W-1:0]           wait_d [NUM_FU];
  logic [NUM_FU-1:0]          kill, eff_req, starved, gnt;
  logic [N-1:0][NUM_FU-1:0]   gnt_bus;
  logic [N-1:0]               slot_used;
  logic [PtrW-1:0]            idx, last_idx;
  logic                       placed, cand;
  int unsigned                pos;

  // Squash kill and starvation flags per FU.
  always_comb begin
    kill    = '0;
    starved = '0;
    for (int j = 0; j < int'(NUM_FU); j++) begin
      kill[j] = (rem_br_task_i == SQUASH_TASK) && (fu_b_id_i[j] != rem_b_id_i) &&
                (|(fu_b_mask_i[j] & rem_b_id_i));
      starved[j] = (wait_q[j] == Limit);
    end
    eff_req = fu_req_i & ~kill;
  end

  // Two circular scans from rr_ptr: starved requesters first, then the rest; slots fill in order.
  always_comb begin
    gnt       = '0;
    gnt_bus   = '0;
    slot_used = '0;
    last_idx  = rr_ptr_q;
    idx       = '0;
    placed    = 1'b0;
    cand      = 1'b0;
    pos       = 0;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < int'(NUM_FU); k++) begin
        pos = 32'(rr_ptr_q) + 32'(k);
        if (pos >= NUM_FU) pos = pos - NUM_FU;
        idx    = PtrW'(pos);
        cand   = (p == 0) ? (eff_req[idx] & starved[idx]) : eff_req[idx];
        placed = 1'b0;
        if (cand && !gnt[idx]) begin
          for (int s = 0; s < int'(N); s++) begin
            if (!placed && !slot_used[s]) begin
              gnt_bus[s][idx] = 1'b1;
              slot_used[s]    = 1'b1;
              placed          = 1'b1;
            end
          end
          if (placed) begin
            gnt[idx] = 1'b1;
            last_idx = idx;
          end
        end
      end
    end
  end

  // Next-state: pointer moves past the FU in the highest filled slot; wait counters saturate.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (|gnt) begin
      rr_ptr_d = (last_idx == PtrW'(NUM_FU - 1)) ? '0 : last_idx + 1'b1;
    end
    for (int j = 0; j < int'(NUM_FU); j++) begin
      wait_d[j] = wait_q[j];
      if (gnt[j] || !eff_req[j]) begin
        wait_d[j] = '0;
      end else if (wait_q[j] != Limit) begin
        wait_d[j] = wait_q[j] + 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      for (int j = 0; j < int'(NUM_FU); j++) wait_q[j] <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      for (int j = 0; j < int'(NUM_FU); j++) wait_q[j] <= wait_d[j];
    end
  end

  // Decision outputs are held low for as long as reset is asserted.
  always_comb begin
    gnt_o       = rst_n ? gnt : '0;
    gnt_bus_o   = rst_n ? gnt_bus : '0;
    stall_sig_o = rst_n ? (eff_req & ~gnt) : '0;
    rr_ptr_o    = rr_ptr_q;
    starved_o   = starved;
  end

endmodule
